ip_rx_controller: RTL
=====================

# ip_rx_controller

Sequencing controller for the IP header decoder on the receive path. Accepts a 32-bit word stream, one frame per IP datagram, and drives it into the decoder with the correct start alignment. It steers decoded payload words to the TCP or UDP payload buffer by protocol number, then commits or discards each datagram on the decoder's checksum verdict. It also resets the decoder between datagrams and counts accepted and dropped datagrams.

## Interface
Parameters:
- DRAIN_TIMEOUT, 8: max cycles to wait for decoder `fin` after the last input word.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  32  upstream word, network byte order, header word first.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  word is consumed when in_valid && in_ready.
- dec_start  out  1  decoder start.
- dec_data  out  32  decoder data input.
- dec_reset  out  1  decoder reset.
- dec_fin  in  1  decoder finished.
- dec_ok  in  1  header checksum good.
- dec_protocol  in  8  decoded protocol field.
- dec_wr_en  in  1  decoder payload word valid.
- dec_data_out  in  32  decoder payload word.
- dec_len_tcp  in  16  payload byte length.
- tcp_wr_en, udp_wr_en  out  1  payload write strobes.
- pay_data  out  32  payload word, shared by both sinks.
- tcp_commit, tcp_discard, udp_commit, udp_discard  out  1  one-cycle end-of-datagram verdict pulses.
- pay_len  out  16  payload length, valid with any commit pulse.
- cnt_ok, cnt_drop  out  CNT_W  datagrams committed / dropped; both wrap.

## Operation
- States: IDLE, FEED, DRAIN, FLUSH, SKIP.
- `dec_data = in_data` (combinational).
- `dec_reset = reset | (state==FLUSH)`.
- `dec_start = (state==IDLE) & in_valid`. The first word and start reach the decoder in the same cycle.
- IDLE:
  - in_ready=1.
  - A consumed word moves to FEED.
  - If that word also has in_last=1, move to DRAIN.
- FEED:
  - in_ready=1; one word per cycle with no gaps, because the decoder has no backpressure.
  - in_valid=0 is an underrun: set the `abort` flag and go to SKIP.
  - A consumed word with in_last=1 goes to DRAIN; the timeout counter loads 0.
  - Words beyond the datagram length are consumed and ignored.
- SKIP:
  - in_ready=1; discard words until in_last is consumed, then go to FLUSH.
  - Issue a discard pulse to the sink selected by the latched protocol (none if unknown), and increment cnt_drop.
- DRAIN:
  - in_ready=0.
  - On dec_fin=1, issue the verdict and go to FLUSH.
  - If the counter reaches DRAIN_TIMEOUT with dec_fin=0, issue a drop verdict and go to FLUSH.
- FLUSH: in_ready=0; dec_reset=1 for exactly one cycle; next state IDLE.
- Steering:
  - Each cycle, register `pay_data <= dec_data_out`.
  - `tcp_wr_en <= dec_wr_en & (dec_protocol==6) & !abort`.
  - `udp_wr_en <= dec_wr_en & (dec_protocol==17) & !abort`.
  - Any other protocol: no write strobe.
  - The protocol is latched at first dec_wr_en for use by the verdict.
- Verdict:
  - Commit is issued only when dec_ok=1, abort=0, no timeout, and protocol is 6 or 17. It goes to the matching sink with `pay_len <= dec_len_tcp`, and cnt_ok increments.
  - Otherwise a discard pulse goes to the matching sink (TCP or UDP only), and cnt_drop increments.
  - Unknown protocol: no pulse to either sink; cnt_drop still increments.

## Timing
- Reset values:
  - state=IDLE; abort=0.
  - All strobes and pulses 0; pay_data=0; pay_len=0; cnt_ok=cnt_drop=0.
  - in_ready reads 1 once reset deasserts.
- Payload latency: dec_wr_en to tcp_wr_en/udp_wr_en is 1 cycle.
- Ordering: the last payload strobe precedes the verdict pulse by at least 1 cycle.
- The verdict pulse is registered on the edge leaving DRAIN or SKIP and lasts exactly one cycle.
- Back-to-back datagrams: minimum gap of 2 cycles of in_ready=0 (DRAIN exit and FLUSH) after the last word.
- Reset mid-frame:
  - Return to IDLE next edge with no verdict pulse and counters cleared.
  - The decoder is reset through dec_reset.
  - Remaining upstream words of that frame are treated as a new frame; upstream must flush on reset.
- Counter wrap: a counter at all-ones plus one becomes 0 and carries no flag.

## Test plan
- TCP datagram, 7 words, total_length=28, IHL=5, proto 6, valid checksum, payload 0xDEADBEEF, 0x01234567 -> 2 tcp_wr_en with those words; tcp_commit one cycle, pay_len=8; cnt_ok=1.
- Same datagram with a corrupted checksum -> 2 tcp_wr_en, then tcp_discard; cnt_drop=1; no commit.
- UDP (proto 17) datagram immediately followed by a TCP datagram -> udp_commit, then tcp_commit; in_ready low exactly 2 cycles between frames.
- Proto 1, 6 words -> no write strobes, no sink pulses; cnt_drop=1.
- in_valid drops for 1 cycle at word 4 of a 7-word TCP frame -> SKIP until in_last; tcp_discard; no commit; decoder reset pulse observed.
- Frame claims total_length=40 but in_last arrives at word 7 -> timeout after DRAIN_TIMEOUT=8 cycles; tcp_discard; cnt_drop increments.
- reset asserted at word 3 -> all outputs zero next cycle; no verdict; the next clean frame commits normally.

Source files
------------

// File: rtl/ip_rx_controller.sv
// ip_rx_controller: feeds one IP datagram per frame into the header decoder,
// steers payload words to TCP/UDP sinks and commits or discards each datagram.
module ip_rx_controller #(
  parameter int DRAIN_TIMEOUT = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             dec_start,
  output logic [31:0]      dec_data,
  output logic             dec_reset,
  input  logic             dec_fin,
  input  logic             dec_ok,
  input  logic [7:0]       dec_protocol,
  input  logic             dec_wr_en,
  input  logic [31:0]      dec_data_out,
  input  logic [15:0]      dec_len_tcp,
  output logic             tcp_wr_en,
  output logic             udp_wr_en,
  output logic [31:0]      pay_data,
  output logic             tcp_commit,
  output logic             tcp_discard,
  output logic             udp_commit,
  output logic             udp_discard,
  output logic [15:0]      pay_len,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_drop
);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    FLUSH,
    SKIP
  } state_t;

  localparam int TW =
    (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            abort;
  logic [7:0]      proto_q;
  logic            proto_seen;
  logic [7:0]      vproto;
  logic            is_tcp;
  logic            is_udp;
  logic            fin_evt;
  logic            tmo_evt;
  logic            skip_evt;
  logic            verdict;
  logic            good;

  assign dec_data = in_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = in_last ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (!in_valid) begin
          state_nx = SKIP;
        end else if (in_last) begin
          state_nx = DRAIN;
        end
      end
      SKIP: begin
        if (in_valid && in_last) begin
          state_nx = FLUSH;
        end
      end
      DRAIN: begin
        if (dec_fin || tmo_hit) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Handshake and decoder control outputs
  always_comb begin
    in_ready  = (state == IDLE)
              | (state == FEED)
              | (state == SKIP);
    dec_start = (state == IDLE) & in_valid;
    dec_reset = reset | (state == FLUSH);
  end

  // Drain timeout: restarts at 0 on every entry to DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != DRAIN) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  assign tmo_hit = (state == DRAIN)
                 & (tmo_cnt == TMO_LAST);

  // Underrun flag, held until the datagram is flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      abort <= 1'b0;
    end else if (state == FLUSH) begin
      abort <= 1'b0;
    end else if (state == FEED && !in_valid) begin
      abort <= 1'b1;
    end
  end

  // Protocol captured with the first payload word
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_q    <= '0;
      proto_seen <= 1'b0;
    end else if (state == FLUSH) begin
      proto_q    <= '0;
      proto_seen <= 1'b0;
    end else if (dec_wr_en && !proto_seen) begin
      proto_q    <= dec_protocol;
      proto_seen <= 1'b1;
    end
  end

  // Without payload the decoder's own protocol field picks the sink
  assign vproto = proto_seen ? proto_q : dec_protocol;
  assign is_tcp = (vproto == PROTO_TCP);
  assign is_udp = (vproto == PROTO_UDP);

  assign fin_evt  = (state == DRAIN) & dec_fin;
  assign tmo_evt  = tmo_hit & !dec_fin;
  assign skip_evt = (state == SKIP) & in_valid & in_last;
  assign verdict  = fin_evt | tmo_evt | skip_evt;
  assign good     = fin_evt & dec_ok & !abort
                  & (is_tcp | is_udp);

  // Payload steering, one cycle behind the decoder
  always_ff @(posedge clk) begin
    if (reset) begin
      pay_data  <= '0;
      tcp_wr_en <= 1'b0;
      udp_wr_en <= 1'b0;
    end else begin
      pay_data  <= dec_data_out;
      tcp_wr_en <= dec_wr_en
                 & (dec_protocol == PROTO_TCP)
                 & !abort;
      udp_wr_en <= dec_wr_en
                 & (dec_protocol == PROTO_UDP)
                 & !abort;
    end
  end

  // Verdict pulses, registered on the edge leaving DRAIN or SKIP
  always_ff @(posedge clk) begin
    if (reset) begin
      tcp_commit  <= 1'b0;
      tcp_discard <= 1'b0;
      udp_commit  <= 1'b0;
      udp_discard <= 1'b0;
      pay_len     <= '0;
    end else begin
      tcp_commit  <= verdict & good & is_tcp;
      tcp_discard <= verdict & !good & is_tcp;
      udp_commit  <= verdict & good & is_udp;
      udp_discard <= verdict & !good & is_udp;
      if (verdict && good) begin
        pay_len <= dec_len_tcp;
      end
    end
  end

  // Datagram statistics, free-running wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ok   <= '0;
      cnt_drop <= '0;
    end else if (verdict) begin
      if (good) begin
        cnt_ok <= cnt_ok + CNT_ONE;
      end else begin
        cnt_drop <= cnt_drop + CNT_ONE;
      end
    end
  end

endmodule
